eeprom_bist_seq: RTL

//  Parametrised EEPROM built-in self-test sequencer. Drives an iic_com-style

---
 rtl/eeprom_pkg.sv | 32 +++
 rtl/eeprom_pat_gen.sv | 63 ++++++
 rtl/eeprom_bist_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared constants for the EEPROM BIST sequencer.
//   - iic_com command encodings driven on Start_Sig
//   - sequencer FSM state encoding
//   - pattern mode codes and the LFSR8 (x^8+x^6+x^5+x^4+1) step function
package eeprom_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_CHK  = 3'd4,
    S_FIN     = 3'd5
  } state_e;

  localparam logic [1:0] PAT_FIXED = 2'd0;
  localparam logic [1:0] PAT_INC   = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_INV   = 2'd3;

  // Fibonacci form, shifting left: feedback is the XOR of bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/eeprom_pat_gen.sv
// eeprom_pat_gen: test-pattern generator for the BIST sequencer.
// Produces pat(i) for the current index i; the sequencer pulses restart at the
// start of each pass (i=0) and step whenever it advances the index, so the
// write and read passes see the identical sequence.
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   mode       pattern select (PAT_FIXED, PAT_INC, PAT_LFSR, PAT_INV)
//   restart    return to index 0 (wins over step)
//   step       advance to the next index
//   pat        pattern byte for the current index
module eeprom_pat_gen #(
  parameter int         DATA_W = 8,
  parameter logic [7:0] SEED   = 8'h12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              restart,
  input  logic              step,
  output logic [DATA_W-1:0] pat
);
  import eeprom_pkg::*;

  // An all-zero LFSR would lock up, so it is seeded with 1 instead.
  localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [7:0]        lfsr_q, lfsr_d;

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (restart) begin
      cnt_d  = '0;
      lfsr_d = LFSR_INIT;
    end else if (step) begin
      cnt_d  = cnt_q + 1'b1;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_INIT;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    pat = DATA_W'(SEED);
    case (mode)
      PAT_FIXED: pat = DATA_W'(SEED);
      PAT_INC:   pat = DATA_W'(SEED) + cnt_q;
      PAT_LFSR:  pat = DATA_W'(lfsr_q);
      PAT_INV:   pat = DATA_W'(~SEED) + cnt_q;
      default:   pat = DATA_W'(SEED);
    endcase
  end

endmodule

// File: rtl/eeprom_bist_seq.sv
// eeprom_bist_seq: EEPROM built-in self-test sequencer driving an iic_com
// Start_Sig/Done_Sig byte engine. Writes a pattern to NUM_BYTES consecutive
// addresses (waiting tWR after each), reads every byte back, compares, and
// reports pass/fail, a saturating error count and the first failing address.
// Ports:
//   CLK, RST      clock / synchronous active-high reset (also resets iic_com)
//   Run, Mode     start pulse and pattern select (latched on Run)
//   Start_Sig     iic_com command: 01 write, 10 read, 00 idle
//   Addr_Sig      byte address, WrData write byte
//   RdData        read byte, valid with Done_Sig
//   Done_Sig      iic_com transaction complete
//   Busy          test running
//   Pass, Fail    result of the last test
//   Timeout       last test aborted waiting for Done_Sig
//   Err_Cnt       mismatch count (saturating), Fail_Addr first mismatch address
module eeprom_bist_seq #(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 8,
  parameter int         NUM_BYTES = 16,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] SEED      = 8'h12,
  parameter int         TWR_CYC   = 250000,
  parameter int         TO_CYC    = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Run,
  input  logic [1:0]        Mode,
  output logic [1:0]        Start_Sig,
  output logic [ADDR_W-1:0] Addr_Sig,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              Done_Sig,
  output logic              Busy,
  output logic              Pass,
  output logic              Fail,
  output logic              Timeout,
  output logic [ADDR_W:0]   Err_Cnt,
  output logic [ADDR_W-1:0] Fail_Addr
);
  import eeprom_pkg::*;

  localparam int IDX_W   = ADDR_W + 1;
  localparam int TMR_MAX = (TWR_CYC > TO_CYC) ? TWR_CYC : TO_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  // WR_WAIT runs with the timer at 0..TWR_CYC: TWR_CYC idle cycles plus the
  // cycle that advances the index.
  localparam logic [TMR_W-1:0] TWR_LAST = TMR_W'(TWR_CYC);
  // A request times out in its TO_CYC-th cycle without Done_Sig.
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TO_CYC - 1);
  localparam logic [ADDR_W:0]  ERR_MAX  = '1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic                busy_q, busy_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                to_q, to_d;

  logic                pat_restart, pat_step;
  logic [DATA_W-1:0]   pat;
  logic [ADDR_W-1:0]   cur_addr;

  // Address wraps naturally modulo 2**ADDR_W.
  assign cur_addr = ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];

  eeprom_pat_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pat (
    .clk     (CLK),
    .rst     (RST),
    .mode    (mode_q),
    .restart (pat_restart),
    .step    (pat_step),
    .pat     (pat)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    mode_d      = mode_q;
    rd_d        = rd_q;
    err_d       = err_q;
    faddr_d     = faddr_q;
    busy_d      = busy_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    to_d        = to_q;
    pat_restart = 1'b0;
    pat_step    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          mode_d      = Mode;
          err_d       = '0;
          faddr_d     = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          to_d        = 1'b0;
          idx_d       = '0;
          tmr_d       = '0;
          busy_d      = 1'b1;
          pat_restart = 1'b1;
          state_d     = S_WR_REQ;
        end
      end

      // Done_Sig is checked before expiry so a completion in the expiry
      // cycle still counts.
      S_WR_REQ, S_RD_REQ: begin
        if (Done_Sig) begin
          tmr_d = '0;
          if (state_q == S_RD_REQ) begin
            rd_d    = RdData;
            state_d = S_RD_CHK;
          end else begin
            state_d = S_WR_WAIT;
          end
        end else if (tmr_q == TO_LAST) begin
          tmr_d   = '0;
          to_d    = 1'b1;
          fail_d  = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_WR_WAIT: begin
        if (tmr_q == TWR_LAST) begin
          tmr_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            pat_restart = 1'b1;
            state_d     = S_RD_REQ;
          end else begin
            idx_d    = idx_q + 1'b1;
            pat_step = 1'b1;
            state_d  = S_WR_REQ;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RD_CHK: begin
        if (rd_q != pat) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (err_q == '0)      faddr_d = cur_addr;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d    = idx_q + 1'b1;
          pat_step = 1'b1;
          state_d  = S_RD_REQ;
        end
      end

      S_FIN: begin
        pass_d  = (err_q == '0);
        fail_d  = (err_q != '0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= '0;
      rd_q    <= '0;
      err_q   <= '0;
      faddr_q <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  // Bus outputs decode straight from the state register; leaving a request
  // state drops Start_Sig to 00 for at least one cycle.
  always_comb begin
    Start_Sig = CMD_IDLE;
    Addr_Sig  = '0;
    WrData    = '0;
    if (state_q == S_WR_REQ) begin
      Start_Sig = CMD_WR;
      Addr_Sig  = cur_addr;
      WrData    = pat;
    end else if (state_q == S_RD_REQ) begin
      Start_Sig = CMD_RD;
      Addr_Sig  = cur_addr;
    end
  end

  assign Busy      = busy_q;
  assign Pass      = pass_q;
  assign Fail      = fail_q;
  assign Timeout   = to_q;
  assign Err_Cnt   = err_q;
  assign Fail_Addr = faddr_q;

endmodule
